// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH iterations per operation.
// Signed operands are multiplied as magnitudes and the sign is applied when the result is stored.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = PW + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   upper_sum;
  logic [AW-1:0]    acc_step;
  logic [PW-1:0]    prod;
  logic             accept, retire, last_iter;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;
  assign last_iter = (state_q == BUSY) && (cnt_q == CW'(1));

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct as unsigned.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // Accumulator layout: {partial product upper half (WIDTH+1), multiplier remainder (WIDTH)}.
  always_comb begin
    upper_sum = acc_q[PW:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
    acc_step  = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
    prod      = acc_step[PW-1:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = {{(WIDTH + 1){1'b0}}, b_mag};
          mcand_d = a_mag;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_d   = CW'(WIDTH);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (last_iter) begin
          p_d     = neg_q ? (~prod + PW'(1)) : prod;
          state_d = DONE;
        end
      end
      DONE: begin
        if (retire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: WIDTH=8 and WIDTH=2 instances against an integer product model.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 1'b0, ir8, s8 = 1'b0, ov8, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        iv2 = 1'b0, ir2, s2 = 1'b0, ov2, or2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic [3:0]  p2;

  int n_checks = 0;
  int n_fails  = 0;

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .is_signed(s8),
    .out_valid(ov8), .out_ready(or8), .p(p8)
  );

  seq_shift_add_multiplier #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .is_signed(s2),
    .out_valid(ov2), .out_ready(or2), .p(p2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact product of two w-bit operands, reduced to 2*w bits.
  function automatic logic [63:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input bit sv);
    longint x, y, prod;
    x = longint'(av) & ((longint'(1) << w) - 1);
    y = longint'(bv) & ((longint'(1) << w) - 1);
    if (sv && av[w-1]) x = x - (longint'(1) << w);
    if (sv && bv[w-1]) y = y - (longint'(1) << w);
    prod = x * y;
    return 64'(prod) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic cur_ov(input bit sel);
    return sel ? ov2 : ov8;
  endfunction

  function automatic logic cur_ir(input bit sel);
    return sel ? ir2 : ir8;
  endfunction

  function automatic logic [15:0] cur_p(input bit sel);
    return sel ? {12'b0, p2} : p8;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] av, input logic [7:0] bv,
                       input logic sv);
    if (sel) begin
      iv2 = v; a2 = av[1:0]; b2 = bv[1:0]; s2 = sv;
    end else begin
      iv8 = v; a8 = av; b8 = bv; s8 = sv;
    end
  endtask

  task automatic set_ordy(input bit sel, input logic v);
    if (sel) or2 = v;
    else or8 = v;
  endtask

  // Returns at the negedge just after the handshake edge.
  task automatic start_op(input bit sel, input logic [7:0] av, input logic [7:0] bv, input logic sv);
    int n = 0;
    @(negedge clk);
    while (!cur_ir(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 64'(cur_ir(sel)), 64'd1);
    drive(sel, 1'b1, av, bv, sv);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 8'h00, 8'h00, 1'b0);
    check("in_ready_busy", 64'(cur_ir(sel)), 64'd0);
  endtask

  task automatic wait_done(input bit sel, inout int lat);
    while (!cur_ov(sel) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire(input bit sel);
    set_ordy(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(sel, 1'b0);
    check("out_valid_after_retire", 64'(cur_ov(sel)), 64'd0);
    check("in_ready_after_retire", 64'(cur_ir(sel)), 64'd1);
  endtask

  task automatic full_op(input bit sel, input int w, input logic [7:0] av, input logic [7:0] bv,
                         input logic sv, input logic [63:0] exp);
    int lat = 0;
    start_op(sel, av, bv, sv);
    wait_done(sel, lat);
    check("latency", 64'(lat), 64'(w));
    check("product", 64'(cur_p(sel)), exp);
    retire(sel);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hold, seen;
    logic [7:0] ra, rb;
    logic rs;

    #1;
    check("rst_in_ready8", 64'(ir8), 64'd1);
    check("rst_out_valid8", 64'(ov8), 64'd0);
    check("rst_p8", 64'(p8), 64'd0);
    check("rst_p2", 64'(p2), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int s = 0; s < 2; s++)
          full_op(1'b1, 2, 8'(i), 8'(j), s[0], model(2, 32'(i), 32'(j), s[0]));

    full_op(1'b0, 8, 8'hFF, 8'hFF, 1'b0, 64'hFE01);
    full_op(1'b0, 8, 8'h00, 8'hA5, 1'b0, 64'h0000);
    full_op(1'b0, 8, 8'h80, 8'h80, 1'b1, 64'h4000);
    full_op(1'b0, 8, 8'hFD, 8'h05, 1'b1, 64'hFFF1);
    full_op(1'b0, 8, 8'h00, 8'h83, 1'b1, 64'h0000);

    // Backpressure with ignored input pulses while DONE.
    lat = 0;
    start_op(1'b0, 8'h80, 8'h7F, 1'b1);
    wait_done(1'b0, lat);
    check("bp_latency", 64'(lat), 64'd8);
    check("bp_product", 64'(p8), 64'hC080);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      @(negedge clk);
      check("bp_out_valid", 64'(ov8), 64'd1);
      check("bp_p_stable", 64'(p8), 64'hC080);
      check("bp_in_ready", 64'(ir8), 64'd0);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    retire(1'b0);
    check("p_held_after_retire", 64'(p8), 64'hC080);

    // New operands offered while BUSY must not disturb the active operation.
    lat = 0;
    start_op(1'b0, 8'd7, 8'd9, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
      @(negedge clk);
      lat++;
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_done(1'b0, lat);
    check("busy_ignore_latency", 64'(lat), 64'd8);
    check("busy_ignore_product", 64'(p8), 64'd63);
    retire(1'b0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    check("busy_ignore_single_output", 64'(seen), 64'd0);

    // Asynchronous reset three cycles into BUSY.
    start_op(1'b0, 8'hFF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(ov8), 64'd0);
    check("midrst_p", 64'(p8), 64'd0);
    check("midrst_in_ready", 64'(ir8), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    full_op(1'b0, 8, 8'd12, 8'd10, 1'b0, 64'd120);

    // Randomized operations with random backpressure.
    for (int k = 0; k < 60; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      lat = 0;
      start_op(1'b0, ra, rb, rs);
      wait_done(1'b0, lat);
      check("rand_latency", 64'(lat), 64'd8);
      check("rand_product", 64'(p8), model(8, 32'(ra), 32'(rb), rs));
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        @(negedge clk);
        check("rand_hold_product", 64'(p8), model(8, 32'(ra), 32'(rb), rs));
      end
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      retire(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
Iterative shift-add multiplier, parametrised in operand width. Supports unsigned and two's-complement signed modes, selected per operation. Sits where the fixed 2x2 combinational multiplier architectures sit, as the area-lean sequential variant for design-space exploration. Uses valid/ready handshakes on both input and output.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands and mode present on a, b, is_signed
in_ready  output  1  block can accept an operation (high only in IDLE)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = both operands two's complement, 0 = both unsigned
out_valid  output  1  p holds a completed product
out_ready  input  1  downstream accepts p
p  output  2*WIDTH  product

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, p = 0. All internal registers are cleared.
- Reset mid-operation: the operation in progress is discarded and no out_valid is produced. Normal operation resumes on the first clk edge after rst deasserts.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On the edge where in_valid & in_ready, capture a, b and is_signed, load the iteration counter with WIDTH, and go to BUSY.
- Signed preprocessing at capture, when is_signed = 1:
  - Store |a| and |b| as WIDTH-bit unsigned values. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits.
  - Store neg = a[MSB] ^ b[MSB].
  - When is_signed = 0, neg = 0 and operands are stored unchanged.
- BUSY:
  - in_ready = 0. Each edge performs one iteration: if the multiplier LSB is 1, add the multiplicand into the upper half of the 2*WIDTH+1-bit accumulator; then shift the accumulator/multiplier right by 1; decrement the counter.
  - Exactly WIDTH iterations are performed. No early termination on zero operands.
  - On the edge that performs the last iteration, go to DONE and register p = neg ? -acc : acc, truncated to 2*WIDTH bits.
- Latency: if the input handshake occurs on edge k, out_valid rises after edge k+WIDTH. Latency is fixed and data-independent.
- DONE:
  - out_valid = 1 and p is held stable while out_ready = 0.
  - On the edge where out_valid & out_ready, go to IDLE: out_valid = 0 and in_ready = 1 from the next cycle.
  - in_ready stays 0 throughout DONE, so no new operation is accepted in the same cycle as output retirement.
  - Throughput is at most one operation per WIDTH+2 cycles.
- p keeps the last product after retirement until the next DONE entry overwrites it. Only out_valid qualifies p.
- in_valid is ignored in BUSY and DONE. No capture occurs, and the active operation's operands are not disturbed.
- Arithmetic bounds:
  - Unsigned full-scale: (2^W-1)^2 fits in 2*WIDTH bits.
  - Signed extreme: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) is representable positive.
  - Results are exact for all operand pairs in both modes. Zero times any value gives p = 0 in both modes, with no negative zero.
- Mode selection: is_signed is sampled only at capture. Changes during BUSY or DONE have no effect.

Test Plan:
- WIDTH=2, unsigned, exhaustive 16 pairs (e.g. a=3, b=3) -> p=4'h9. out_valid rises exactly 2 cycles after the handshake edge.
- WIDTH=8, unsigned, a=8'hFF, b=8'hFF -> p=16'hFE01 after 8 cycles. Also a=0, b=8'hA5 -> p=16'h0000.
- WIDTH=8, signed:
  - a=8'h80, b=8'h80 -> p=16'h4000.
  - a=8'hFD (-3), b=8'h05 -> p=16'hFFF1 (-15).
  - a=8'h80, b=8'h7F -> p=16'hC080.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> out_valid stays 1, p is unchanged, in_ready=0, and in_valid pulses are ignored. Raising out_ready gives in_ready=1 one cycle later.
- Input ignored while busy: apply a second in_valid with new operands during BUSY -> the first product is unaffected, and only one out_valid is produced.
- Reset mid-operation: assert rst 3 cycles into BUSY -> out_valid=0, p=0 and in_ready=1 immediately (asynchronously). The next operation after release, 12*10, gives p=16'd120 with normal latency.
